// File: rtl/lab_pkg.sv
// Shared definitions for the serial shift-register lab path: transmitter state
// encoding and the default data width used by both transmitter and receiver.
package lab_pkg;

  localparam int DATA_W = 4;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_SHIFT = 2'd1;
  localparam logic [1:0] TX_PAR   = 2'd2;
  localparam logic [1:0] TX_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = TX_IDLE,
    ST_SHIFT = TX_SHIFT,
    ST_PAR   = TX_PAR,
    ST_DONE  = TX_DONE
  } tx_state_e;

endpackage

// File: rtl/piso_tx_if.sv
// Handshake and serial-line bundle between a word source (master) and the
// parallel-in/serial-out transmitter (slave).
interface piso_tx_if import lab_pkg::*; #(
  parameter int WIDTH = DATA_W
) ();

  logic             tick;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             so;
  logic             so_valid;
  logic             ready;
  logic             done;

  modport master (
    output tick, load, d,
    input  so, so_valid, ready, done
  );

  modport slave (
    input  tick, load, d,
    output so, so_valid, ready, done
  );

endinterface

// File: rtl/tx_bit_counter.sv
// Bit-position counter for the transmitter: synchronous clear, count enable,
// and a terminal flag while the last data bit (WIDTH-1) is on the line.
module tx_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: loads a word in IDLE and shifts it out one
// bit per tick. Define TX_PARITY_EN to append an even-parity bit to each frame.
module piso_tx import lab_pkg::*; #(
  parameter int WIDTH     = DATA_W,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  piso_tx_if.slave      bus
);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, sreg_sh;
  logic             so_q, so_d;
  logic             so_valid_q, so_valid_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             cnt_clr, cnt_en, cnt_tc;
`ifdef TX_PARITY_EN
  logic             par_q, par_d;
`endif

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  tx_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  always_comb begin
    if (LSB_FIRST) sreg_sh = sreg_q >> 1;
    else           sreg_sh = sreg_q << 1;
  end

  // Next-state logic; so_d always holds the bit the line shows next cycle.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    so_d       = so_q;
    so_valid_d = so_valid_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
`ifdef TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          state_d    = ST_SHIFT;
          sreg_d     = bus.d;
          so_d       = head_bit(bus.d);
          so_valid_d = 1'b1;
          ready_d    = 1'b0;
          cnt_clr    = 1'b1;
`ifdef TX_PARITY_EN
          par_d      = ^bus.d;
`endif
        end
      end
      ST_SHIFT: begin
        if (bus.tick) begin
          sreg_d = sreg_sh;
          if (cnt_tc) begin
`ifdef TX_PARITY_EN
            state_d    = ST_PAR;
            so_d       = par_q;
`else
            state_d    = ST_DONE;
            so_d       = 1'b0;
            so_valid_d = 1'b0;
            done_d     = 1'b1;
`endif
          end else begin
            cnt_en = 1'b1;
            so_d   = head_bit(sreg_sh);
          end
        end
      end
`ifdef TX_PARITY_EN
      ST_PAR: begin
        if (bus.tick) begin
          state_d    = ST_DONE;
          so_d       = 1'b0;
          so_valid_d = 1'b0;
          done_d     = 1'b1;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d    = ST_IDLE;
        so_d       = 1'b0;
        so_valid_d = 1'b0;
        ready_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sreg_q     <= '0;
      so_q       <= 1'b0;
      so_valid_q <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
`ifdef TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      so_q       <= so_d;
      so_valid_q <= so_valid_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
`ifdef TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign bus.so       = so_q;
  assign bus.so_valid = so_valid_q;
  assign bus.ready    = ready_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: an MSB-first and an LSB-first instance share the
// same stimulus; frame length follows TX_PARITY_EN.
module tb_piso_tx;

  localparam int W = 4;
`ifdef TX_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tick = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] d = '0;

  int checks = 0;
  int errors = 0;

  piso_tx_if #(.WIDTH(W)) mif ();
  piso_tx_if #(.WIDTH(W)) lif ();

  assign mif.tick = tick;
  assign mif.load = load;
  assign mif.d    = d;
  assign lif.tick = tick;
  assign lif.load = load;
  assign lif.d    = d;

  piso_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (.clk(clk), .rst(rst), .bus(mif));
  piso_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (.clk(clk), .rst(rst), .bus(lif));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {so, so_valid, ready, done} of MSB instance, then LSB instance
  function automatic logic [7:0] obs();
    return {mif.so, mif.so_valid, mif.ready, mif.done,
            lif.so, lif.so_valid, lif.ready, lif.done};
  endfunction

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; d = 4'hF;
    for (int c = 0; c < 3; c++) begin
      tick = (c != 1);
      step();
      checks++;
      if (obs() !== 8'b0010_0010) begin
        errors++;
        $display("FAIL reset_hold c=%0d got %b exp %b", c, obs(), 8'b0010_0010);
      end
    end
    rst = 1'b0; load = 1'b0; tick = 1'b0;
    step();
    checks++;
    if (obs() !== 8'b0010_0010) begin
      errors++;
      $display("FAIL reset_release got %b exp %b", obs(), 8'b0010_0010);
    end
  endtask

  task automatic test_msb_lsb();
    logic [4:0] em = 5'b11101;
    logic [4:0] el = 5'b11011;
    load = 1'b1; d = 4'b1011;
    step();
    load = 1'b0;
    for (int k = 0; k < NB; k++) begin
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (obs() !== {em[k], 3'b100, el[k], 3'b100}) begin
          errors++;
          $display("FAIL frame1011 bit%0d c=%0d got %b exp %b", k, c, obs(), {em[k], 3'b100, el[k], 3'b100});
        end
        tick = (c == 3);
        step();
        tick = 1'b0;
      end
    end
    checks++;
    if (obs() !== 8'b0001_0001) begin
      errors++;
      $display("FAIL frame1011_done got %b exp %b", obs(), 8'b0001_0001);
    end
    step();
    checks++;
    if (obs() !== 8'b0010_0010) begin
      errors++;
      $display("FAIL frame1011_ready got %b exp %b", obs(), 8'b0010_0010);
    end
  endtask

  task automatic test_load_busy();
    logic [4:0] em = 5'b00110;
    logic [4:0] el = 5'b00110;
    load = 1'b1; d = 4'b0110;
    step();
    load = 1'b0;
    for (int k = 0; k < NB; k++) begin
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (obs() !== {em[k], 3'b100, el[k], 3'b100}) begin
          errors++;
          $display("FAIL load_busy bit%0d c=%0d got %b exp %b", k, c, obs(), {em[k], 3'b100, el[k], 3'b100});
        end
        if (k == 1 && c == 1) begin
          load = 1'b1; d = 4'b1111;
        end
        tick = (c == 3);
        step();
        tick = 1'b0; load = 1'b0;
      end
    end
    checks++;
    if (obs() !== 8'b0001_0001) begin
      errors++;
      $display("FAIL load_busy_done got %b exp %b", obs(), 8'b0001_0001);
    end
    step();
    checks++;
    if (obs() !== 8'b0010_0010) begin
      errors++;
      $display("FAIL load_busy_ready got %b exp %b", obs(), 8'b0010_0010);
    end
  endtask

  task automatic test_load_tick();
    logic [4:0] em = 5'b00011;
    logic [4:0] el = 5'b01100;
    load = 1'b1; tick = 1'b1; d = 4'b1100;
    step();
    load = 1'b0; tick = 1'b0;
    for (int k = 0; k < NB; k++) begin
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (obs() !== {em[k], 3'b100, el[k], 3'b100}) begin
          errors++;
          $display("FAIL load_tick bit%0d c=%0d got %b exp %b", k, c, obs(), {em[k], 3'b100, el[k], 3'b100});
        end
        tick = (c == 3);
        step();
        tick = 1'b0;
      end
    end
    checks++;
    if (obs() !== 8'b0001_0001) begin
      errors++;
      $display("FAIL load_tick_done got %b exp %b", obs(), 8'b0001_0001);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [4:0] em = 5'b11000;
    logic [4:0] el = 5'b10001;
    load = 1'b1; d = 4'b1011;
    step();
    load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) begin
        tick = (c == 3);
        step();
        tick = 1'b0;
      end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (obs() !== 8'b0010_0010) begin
      errors++;
      $display("FAIL reset_mid got %b exp %b", obs(), 8'b0010_0010);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (obs() !== 8'b0010_0010) begin
        errors++;
        $display("FAIL reset_mid_idle c=%0d got %b exp %b", c, obs(), 8'b0010_0010);
      end
    end
    load = 1'b1; d = 4'b0001;
    step();
    load = 1'b0;
    for (int k = 0; k < NB; k++) begin
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (obs() !== {em[k], 3'b100, el[k], 3'b100}) begin
          errors++;
          $display("FAIL after_reset bit%0d c=%0d got %b exp %b", k, c, obs(), {em[k], 3'b100, el[k], 3'b100});
        end
        tick = (c == 3);
        step();
        tick = 1'b0;
      end
    end
    checks++;
    if (obs() !== 8'b0001_0001) begin
      errors++;
      $display("FAIL after_reset_done got %b exp %b", obs(), 8'b0001_0001);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [9:0] em = {5'b11110, 5'b01001};
    logic [9:0] el = {5'b10111, 5'b01001};
    load = 1'b1; d = 4'b1001;
    step();
    load = 1'b0;
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < NB; k++) begin
        for (int c = 0; c < 2; c++) begin
          checks++;
          if (obs() !== {em[w*5+k], 3'b100, el[w*5+k], 3'b100}) begin
            errors++;
            $display("FAIL b2b w%0d bit%0d c=%0d got %b exp %b", w, k, c, obs(), {em[w*5+k], 3'b100, el[w*5+k], 3'b100});
          end
          tick = (c == 1);
          step();
          tick = 1'b0;
        end
      end
      checks++;
      if (obs() !== 8'b0001_0001) begin
        errors++;
        $display("FAIL b2b_done w%0d got %b exp %b", w, obs(), 8'b0001_0001);
      end
      if (w == 0) begin
        load = 1'b1; d = 4'b0111;
      end
      step();
      checks++;
      if (obs() !== 8'b0010_0010) begin
        errors++;
        $display("FAIL b2b_ready w%0d got %b exp %b", w, obs(), 8'b0010_0010);
      end
      if (w == 0) begin
        step();
        load = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_lsb();
    test_load_busy();
    test_load_tick();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in/serial-out transmitter: the sending end of the serial-in shift-register path. It accepts a WIDTH-bit word on a one-cycle load strobe and drives it one bit per `tick` onto a serial line suitable for a downstream `si` input. It sits between switch/one-shot input logic and a serial receiver, and flags completion with ready/done handshake signals.

## Interface
- `WIDTH`, default 4: data word width in bits; legal range 2..16.
- `LSB_FIRST`, default 0: 0 sends the MSB first, 1 sends the LSB first.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `tick`  input  1  shift-enable pulse, one `clk` cycle wide, for example from the clock divider or one-shot.
- `load`  input  1  one-cycle request to transmit `d`.
- `d`  input  WIDTH  word to send; sampled only when a load is accepted.
- `so`  output  1  serial data out.
- `so_valid`  output  1  high while `so` carries a data or parity bit.
- `ready`  output  1  high when idle and able to accept `load`.
- `done`  output  1  one-cycle pulse after the last bit period ends.

## Operation
- **States:**
  - IDLE: `ready`=1, `so`=0, `so_valid`=0.
  - SHIFT: a data bit is on `so`, `so_valid`=1.
  - PAR: the parity bit is on `so`. This state exists only when parity is compiled in.
  - DONE: `done`=1 for exactly one cycle, then the block returns to IDLE.
- **IDLE to SHIFT:** on `load`=1 while `ready`=1.
  - `d` is captured into the shift register.
  - The bit counter is cleared to 0.
- **Load is accepted only in IDLE.** A `load` in any other state is ignored and does not corrupt the word in flight.
- **SHIFT:**
  - `so` = current MSB of the shift register (or LSB when `LSB_FIRST`=1).
  - Each `tick` shifts the register by one position and increments the counter.
  - The tick that ends bit WIDTH-1 goes to PAR (with `TX_PARITY_EN`), otherwise to DONE.
- **PAR:** `so` = even parity (XOR reduction) of the captured word. The next `tick` goes to DONE.
- **Ticks in IDLE and DONE are ignored.**
- **`load` and `tick` high in the same IDLE cycle:** the load is accepted and the tick is discarded. The first bit is therefore held for one full tick interval.
- **Counter width:** `$clog2(WIDTH)`. It never wraps within a word; it clears on every accepted load.
- **Reset mid-operation:** the block returns to IDLE, the word is dropped and no `done` is issued.

## Timing
- **Reset values:** state IDLE, `so`=0, `so_valid`=0, `ready`=1, `done`=0, shift register and counter 0.
- **Load to first bit:**
  - Load accepted in cycle N.
  - From cycle N+1: first bit on `so`, `so_valid`=1, `ready`=0.
- **Bit timing:** bit k is held from the cycle after tick k-1 until the cycle after tick k. `so` changes only in the cycle after a tick.
- **Completion:**
  - In the cycle after the final tick (the WIDTH-th tick, or the (WIDTH+1)-th with parity): `done`=1, `so_valid`=0, `so`=0.
  - In the following cycle: `ready`=1.
- **Earliest back-to-back load:** accepted the cycle `ready` rises. Total span is WIDTH (+1 with parity) ticks plus 2 `clk` cycles.
- **All outputs are registered.** There is no combinational path from inputs to outputs.

## Configuration
- **`TX_PARITY_EN` defined:**
  - The PAR state is present.
  - One even-parity bit follows the data bits.
  - A frame is WIDTH+1 bit periods.
- **`TX_PARITY_EN` undefined:**
  - PAR is removed.
  - SHIFT goes directly to DONE.
  - A frame is WIDTH bit periods.

## Structure
- **Shared package `lab_pkg`** holds:
  - The state encoding localparams TX_IDLE, TX_SHIFT, TX_PAR, TX_DONE (2-bit).
  - The default width constant DATA_W=4, shared with the receiving shift register.
- **Sub-module:** a single one, `tx_bit_counter` (clear, enable, terminal-count flag at WIDTH-1). The FSM and shift register stay in `piso_tx`.

## Test plan
- **Reset:** hold `rst` for 3 cycles while `load`=1 and `tick` pulses. Outputs stay at their reset values, `ready`=1, and no `done` occurs.
- **MSB first:** WIDTH=4, `d`=4'b1011, tick every 4 cycles, parity off.
  - `so` sequence is 1,0,1,1 with `so_valid`=1 throughout.
  - A single `done` pulse appears one cycle after the 4th tick.
- **LSB first with parity:** `LSB_FIRST`=1, `TX_PARITY_EN` defined, `d`=4'b1011.
  - `so` sequence is 1,1,0,1, then parity bit 1.
  - `done` appears after the 5th tick.
- **Load while busy:** `d`=4'b0110 accepted, then `load` with `d`=4'b1111 during the 2nd bit. Output is still 0,1,1,0 and exactly one `done` is issued.
- **Simultaneous load and tick in IDLE:** the first bit is held until the next tick. Four further ticks produce all 4 bits and `done`.
- **Reset mid-frame:** assert `rst` after the 2nd tick.
  - The next cycle shows `so`=0, `so_valid`=0, `ready`=1, and no `done`.
  - A new load of 4'b0001 transmits correctly.
